// File: rtl/subbytes_sched_pkg.sv
// Shared widths, FSM encoding and chunk-count helper for the shared S-box scheduler.
// Pure declarations: no latency, no flow control.
package subbytes_sched_pkg;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    ST_RUN,
    KW_RUN
  } state_t;

  // Number of bank passes needed to cover one 128-bit state block.
  function automatic int chunks(input int lanes);
    return BLOCK_W / (BYTE_W * lanes);
  endfunction

endpackage

// File: rtl/subbytes_sched_if.sv
// Request/result bundle between the round controller / key expansion (master) and the scheduler (slave).
// Valid/ready requests; result pulses carry no backpressure.
interface subbytes_sched_if;
  import subbytes_sched_pkg::*;

  logic               st_valid;
  logic               st_ready;
  logic [BLOCK_W-1:0] st_data;
  logic               st_res_valid;
  logic [BLOCK_W-1:0] st_res;
  logic               kw_valid;
  logic               kw_ready;
  logic [WORD_W-1:0]  kw_data;
  logic               kw_res_valid;
  logic [WORD_W-1:0]  kw_res;
  logic               busy;

  modport slave (
    input  st_valid, st_data, kw_valid, kw_data,
    output st_ready, st_res_valid, st_res, kw_ready, kw_res_valid, kw_res, busy
  );

  modport master (
    output st_valid, st_data, kw_valid, kw_data,
    input  st_ready, st_res_valid, st_res, kw_ready, kw_res_valid, kw_res, busy
  );

endinterface

// File: rtl/subbytes_sched_sbox_bank.sv
// AES byte S-box (GF(2^8) inverse + affine map) and a bank of LANES of them.
// Purely combinational, zero latency, no flow control.
module sbox
  import subbytes_sched_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  output logic [BYTE_W-1:0] y
);

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign y = affine(ginv(a));

endmodule

module sbox_bank
  import subbytes_sched_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [BYTE_W*LANES-1:0] din,
  output logic [BYTE_W*LANES-1:0] dout
);

  // Lane 0 occupies the most significant byte.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sbox u_sbox (
      .a (din [BYTE_W*LANES-1-BYTE_W*i -: BYTE_W]),
      .y (dout[BYTE_W*LANES-1-BYTE_W*i -: BYTE_W])
    );
  end

endmodule

// File: rtl/subbytes_sched.sv
// Time-multiplexes one LANES-wide S-box bank between 128-bit SubBytes and 32-bit SubWord requests.
// Latency: state 16/LANES cycles, key word 1 cycle; one request in flight, results are pulses with no backpressure.
module subbytes_sched
  import subbytes_sched_pkg::*;
#(
  parameter int LANES = 4
) (
  input logic            clk,
  input logic            rst_n,
  subbytes_sched_if.slave bus
);

  localparam int N       = chunks(LANES);
  localparam int SLICE_W = BYTE_W * LANES;
  localparam int CW      = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $fatal(1, "subbytes_sched: LANES must be 4, 8 or 16");
  end

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               last_st;
  logic [BLOCK_W-1:0] st_cap;
  logic [WORD_W-1:0]  kw_cap;
  logic [BLOCK_W-1:0] st_res_q;
  logic [WORD_W-1:0]  kw_res_q;
  logic               st_res_vld_q;
  logic               kw_res_vld_q;
  logic [SLICE_W-1:0] bank_in;
  logic [SLICE_W-1:0] bank_out;
  logic               st_ready;
  logic               kw_ready;

  // On a tie, last_st picks the requester that was not served last.
  assign st_ready = (state == IDLE) && (!bus.kw_valid || !last_st);
  assign kw_ready = (state == IDLE) && (!bus.st_valid || last_st);

  assign bus.st_ready     = st_ready;
  assign bus.kw_ready     = kw_ready;
  assign bus.st_res       = st_res_q;
  assign bus.kw_res       = kw_res_q;
  assign bus.st_res_valid = st_res_vld_q;
  assign bus.kw_res_valid = kw_res_vld_q;
  assign bus.busy         = (state != IDLE);

  always_comb begin
    bank_in = '0;
    case (state)
      ST_RUN: begin
        for (int k = 0; k < N; k++) begin
          if (cnt == CW'(k)) bank_in = st_cap[BLOCK_W-1-SLICE_W*k -: SLICE_W];
        end
      end
      KW_RUN:  bank_in[SLICE_W-1 -: WORD_W] = kw_cap;
      default: bank_in = '0;
    endcase
  end

  sbox_bank #(.LANES(LANES)) u_bank (
    .din  (bank_in),
    .dout (bank_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last_st      <= 1'b1;
      st_cap       <= '0;
      kw_cap       <= '0;
      st_res_q     <= '0;
      kw_res_q     <= '0;
      st_res_vld_q <= 1'b0;
      kw_res_vld_q <= 1'b0;
    end else begin
      st_res_vld_q <= 1'b0;
      kw_res_vld_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.st_valid && st_ready) begin
            st_cap  <= bus.st_data;
            cnt     <= '0;
            last_st <= 1'b1;
            state   <= ST_RUN;
          end else if (bus.kw_valid && kw_ready) begin
            kw_cap  <= bus.kw_data;
            last_st <= 1'b0;
            state   <= KW_RUN;
          end
        end
        ST_RUN: begin
          // Slices not yet reached keep the previous result's bytes.
          for (int k = 0; k < N; k++) begin
            if (cnt == CW'(k)) st_res_q[BLOCK_W-1-SLICE_W*k -: SLICE_W] <= bank_out;
          end
          if (cnt == CW'(N - 1)) begin
            cnt          <= '0;
            st_res_vld_q <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        KW_RUN: begin
          kw_res_q     <= bank_out[SLICE_W-1 -: WORD_W];
          kw_res_vld_q <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
